// File: rtl/shift_tap_line_if.sv
// Sample/tap bundle for the tapped delay line.
// The master drives samples; the slave (the line) returns the taps, status and fill level.
interface shift_tap_line_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 7
);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] data;
  logic              load;
  logic              flush;
  logic [DATA_W-1:0] P1;
  logic [DATA_W-1:0] P2;
  logic [DATA_W-1:0] abs_diff;
  logic              out_valid;
  logic [FILL_W-1:0] fill;

  modport master (
    output data, load, flush,
    input  P1, P2, abs_diff, out_valid, fill
  );

  modport slave (
    input  data, load, flush,
    output P1, P2, abs_diff, out_valid, fill
  );
endinterface

// File: rtl/shift_tap_line.sv
// Tapped delay line: shifts one sample per load through DEPTH stages and presents
// a far and a near tap, their absolute difference, a primed-data strobe and the fill level.
module shift_tap_line #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 7,
  parameter int unsigned TAP_A  = 7,
  parameter int unsigned TAP_B  = 1
) (
  input  logic          clk,
  input  logic          reset,
  shift_tap_line_if.slave bus
);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  // Reject configurations that would index outside the line or mismatch the bus.
  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("shift_tap_line: DEPTH must be at least 2");
    end
    if (TAP_A < 1 || TAP_A > DEPTH) begin : g_bad_tap_a
      $error("shift_tap_line: TAP_A must lie in 1..DEPTH");
    end
    if (TAP_B < 1 || TAP_B > DEPTH) begin : g_bad_tap_b
      $error("shift_tap_line: TAP_B must lie in 1..DEPTH");
    end
    if ($bits(bus.data) != DATA_W || $bits(bus.fill) != FILL_W) begin : g_bad_bus
      $error("shift_tap_line: interface widths do not match DATA_W/DEPTH");
    end
  endgenerate

  logic [DATA_W-1:0] r_mem [1:DEPTH];
  logic [DATA_W-1:0] r_p1;
  logic [DATA_W-1:0] r_p2;
  logic [DATA_W-1:0] r_abs_diff;
  logic              r_out_valid;
  logic [FILL_W-1:0] r_fill;

  logic              w_shift;
  logic [DATA_W:0]   w_diff_raw;
  logic [DATA_W-1:0] w_abs;
  logic              w_primed;

  // Flush outranks load, so a sample offered with flush is dropped.
  assign w_shift    = bus.load && !bus.flush;
  assign w_diff_raw = {1'b0, r_mem[TAP_A]} - {1'b0, r_mem[TAP_B]};
  assign w_abs      = w_diff_raw[DATA_W] ? DATA_W'(-w_diff_raw) : w_diff_raw[DATA_W-1:0];
  assign w_primed   = (r_fill >= FILL_W'(TAP_A));

  // Delay stages; stage 1 holds the newest sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= int'(DEPTH); k++) begin
        r_mem[k] <= '0;
      end
    end else if (bus.flush) begin
      for (int k = 1; k <= int'(DEPTH); k++) begin
        r_mem[k] <= '0;
      end
    end else if (bus.load) begin
      r_mem[1] <= bus.data;
      for (int k = 2; k <= int'(DEPTH); k++) begin
        r_mem[k] <= r_mem[k-1];
      end
    end
  end

  // Taps capture the pre-shift stage contents and hold across flush and idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p1       <= '0;
      r_p2       <= '0;
      r_abs_diff <= '0;
    end else if (w_shift) begin
      r_p1       <= r_mem[TAP_A];
      r_p2       <= r_mem[TAP_B];
      r_abs_diff <= w_abs;
    end
  end

  // Fill saturates at DEPTH; the strobe only marks loads that saw a primed far tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill      <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_fill      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.load && w_primed;
      if (bus.load && (r_fill != FILL_W'(DEPTH))) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  assign bus.P1        = r_p1;
  assign bus.P2        = r_p2;
  assign bus.abs_diff  = r_abs_diff;
  assign bus.out_valid = r_out_valid;
  assign bus.fill      = r_fill;

endmodule
